vp_instr_sequencer: RTL and testbench



---
 rtl/vp_instr_sequencer.sv | 133 +++++++++++++
 tb/tb_vp_instr_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vp_instr_sequencer.sv
// rtl/vp_instr_sequencer.sv - instruction fetch/issue sequencer for the vector processor
//
// Fetches instruction words from a synchronous-read instruction memory,
// latches them into IR and presents the op_code/operand to the control unit.
// It also handles start/halt, datapath stall and a saturating retire counter.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        begin execution at address 0 (honoured in IDLE/DONE only)
//   stall        datapath busy, holds the current issue
//   imem_rdata   instruction word, valid the cycle after imem_re
//   imem_addr    instruction memory address (the PC)
//   imem_re      instruction memory read strobe
//   op_code      opcode to control unit, NOP (3'b010) when not issuing
//   operand      operand field of the issued instruction, 0 when not issuing
//   issue_valid  op_code/operand carry a live instruction
//   busy         high in FETCH, DECODE, ISSUE
//   done         high in DONE (program reached HALT)
//   instr_count  instructions retired since last start, saturating
module vp_instr_sequencer #(
   parameter int IW    = 16,
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stall,
   input  logic [IW-1:0]    imem_rdata,
   output logic [PC_W-1:0]  imem_addr,
   output logic             imem_re,
   output logic [2:0]       op_code,
   output logic [IW-4:0]    operand,
   output logic             issue_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [2:0]       OP_HALT = 3'b011;
   localparam logic [2:0]       OP_NOP  = 3'b010;
   localparam logic [PC_W-1:0]  PC_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [PC_W-1:0]  pc, pc_nxt;
   logic [IW-1:0]    ir, ir_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         pc    <= '0;
         ir    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ir    <= ir_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      ir_nxt    = ir;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               pc_nxt    = '0;
               cnt_nxt   = '0;
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            state_nxt = S_DECODE;
         end
         S_DECODE: begin
            // HALT is latched but never issued or counted; PC stays on it
            ir_nxt = imem_rdata;
            if (imem_rdata[IW-1:IW-3] == OP_HALT) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Retire happens only on the single edge where stall is low
            if (!stall) begin
               pc_nxt = pc + PC_ONE;
               if (cnt != CNT_MAX) begin
                  cnt_nxt = cnt + CNT_ONE;
               end
               state_nxt = S_FETCH;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs decode from state/IR/PC/count only, so start and stall never
   // reach an output combinationally.
   always_comb begin
      imem_addr   = pc;
      imem_re     = (state == S_FETCH);
      op_code     = OP_NOP;
      operand     = '0;
      issue_valid = 1'b0;
      busy        = (state == S_FETCH) || (state == S_DECODE) || (state == S_ISSUE);
      done        = (state == S_DONE);
      instr_count = cnt;
      if (state == S_ISSUE) begin
         op_code     = ir[IW-1:IW-3];
         operand     = ir[IW-4:0];
         issue_valid = 1'b1;
      end
   end

endmodule

// File: tb/tb_vp_instr_sequencer.sv
// tb/tb_vp_instr_sequencer.sv - directed self-checking bench for vp_instr_sequencer
module tb_vp_instr_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   = 1'b0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic [7:0]  imem_addr;
   logic        imem_re;
   logic [2:0]  op_code;
   logic [12:0] operand;
   logic        issue_valid;
   logic        busy;
   logic        done;
   logic [15:0] instr_count;

   logic        start2 = 1'b0;
   logic        stall2 = 1'b0;
   logic [15:0] imem_rdata2 = '0;
   logic [1:0]  imem_addr2;
   logic        imem_re2;
   logic [2:0]  op_code2;
   logic [12:0] operand2;
   logic        issue_valid2;
   logic        busy2;
   logic        done2;
   logic [1:0]  instr_count2;

   logic [15:0] mem  [0:255];
   logic [15:0] mem2 [0:3];

   int vectors    = 0;
   int miscompares = 0;

   vp_instr_sequencer #(.IW(16), .PC_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .imem_rdata(imem_rdata), .imem_addr(imem_addr), .imem_re(imem_re),
      .op_code(op_code), .operand(operand), .issue_valid(issue_valid),
      .busy(busy), .done(done), .instr_count(instr_count)
   );

   vp_instr_sequencer #(.IW(16), .PC_W(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .stall(stall2),
      .imem_rdata(imem_rdata2), .imem_addr(imem_addr2), .imem_re(imem_re2),
      .op_code(op_code2), .operand(operand2), .issue_valid(issue_valid2),
      .busy(busy2), .done(done2), .instr_count(instr_count2)
   );

   always @(posedge clk) begin
      if (imem_re)  imem_rdata  <= mem[imem_addr];
      if (imem_re2) imem_rdata2 <= mem2[imem_addr2];
   end

   function automatic logic [15:0] mk(input logic [2:0] op, input logic [12:0] opd);
      return {op, opd};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Program 000/100/101/HALT, entered just after the start edge (t=0 is FETCH).
   // start is pulsed in FETCH and ISSUE and must be ignored.
   task automatic run_prog3();
      logic [2:0]  eop;
      logic [12:0] eopd;
      for (int t = 0; t <= 11; t++) begin
         eop  = 3'b010;
         eopd = '0;
         if (t == 2) begin eop = 3'b000; eopd = 13'h0123; end
         if (t == 5) begin eop = 3'b100; eopd = 13'h00aa; end
         if (t == 8) begin eop = 3'b101; eopd = 13'h1fff; end
         chk("p3_valid", issue_valid, (t == 2 || t == 5 || t == 8));
         chk("p3_op", op_code, eop);
         chk("p3_operand", operand, eopd);
         chk("p3_done", done, (t == 11));
         chk("p3_busy", busy, (t != 11));
         if (t % 3 == 0 && t < 11) begin
            chk("p3_re", imem_re, 1);
            chk("p3_addr", imem_addr, t / 3);
         end
         start = (t == 0 || t == 2);
         tick();
      end
      start = 1'b0;
      chk("p3_end_done", done, 1);
      chk("p3_end_count", instr_count, 3);
      chk("p3_end_addr", imem_addr, 3);
      chk("p3_end_busy", busy, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      for (int i = 0; i < 4; i++) mem2[i] = mk(3'b000, 13'(i));

      // 1: asynchronous reset, checked before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_op", op_code, 3'b010);
      chk("rst_operand", operand, 0);
      chk("rst_valid", issue_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", instr_count, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_re", imem_re, 0);
      chk("rst2_op", op_code2, 3'b010);
      chk("rst2_count", instr_count2, 0);
      #5 rst = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      // 2 and 4a: straight-line program, start ignored while busy
      mem[0] = mk(3'b000, 13'h0123);
      mem[1] = mk(3'b100, 13'h00aa);
      mem[2] = mk(3'b101, 13'h1fff);
      mem[3] = mk(3'b011, 13'h0000);
      start = 1'b1;
      tick();
      start = 1'b0;
      run_prog3();

      // 4b: restart from DONE
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rs_done", done, 0);
      chk("rs_count", instr_count, 0);
      chk("rs_addr", imem_addr, 0);
      chk("rs_busy", busy, 1);
      run_prog3();

      // 3: stall held for 4 cycles on the 110 issue, stall in FETCH/DECODE ignored
      mem[0] = mk(3'b000, 13'h0011);
      mem[1] = mk(3'b110, 13'h0abc);
      mem[2] = mk(3'b011, 13'h0000);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t <= 12; t++) begin
         chk("st_valid", issue_valid, (t == 2 || (t >= 5 && t <= 9)));
         if (t >= 5 && t <= 9) begin
            chk("st_op", op_code, 3'b110);
            chk("st_operand", operand, 13'h0abc);
         end
         chk("st_count", instr_count, (t <= 2) ? 0 : ((t <= 9) ? 1 : 2));
         chk("st_done", done, (t == 12));
         stall = (t >= 3 && t <= 8);
         tick();
      end
      stall = 1'b0;

      // 6: reset during a stalled issue, then clean restart
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 5; t++) tick();
      chk("rs6_valid_pre", issue_valid, 1);
      chk("rs6_count_pre", instr_count, 1);
      stall = 1'b1;
      tick();
      tick();
      chk("rs6_held", op_code, 3'b110);
      #2 rst = 1'b1;
      #1;
      chk("rs6_valid", issue_valid, 0);
      chk("rs6_op", op_code, 3'b010);
      chk("rs6_count", instr_count, 0);
      chk("rs6_busy", busy, 0);
      chk("rs6_addr", imem_addr, 0);
      rst = 1'b0;
      stall = 1'b0;
      tick();
      chk("rs6_idle", busy, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rs6_re", imem_re, 1);
      chk("rs6_addr0", imem_addr, 0);
      tick();
      tick();
      chk("rs6_issue", issue_valid, 1);
      chk("rs6_issue_op", op_code, 3'b000);
      chk("rs6_issue_operand", operand, 13'h0011);

      // 5: PC wrap and counter saturation on the narrow instance
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int t = 0; t <= 20; t++) begin
         if (t % 3 == 0) begin
            chk("w_re", imem_re2, 1);
            chk("w_addr", imem_addr2, (t / 3) % 4);
         end
         chk("w_valid", issue_valid2, (t % 3 == 2));
         chk("w_count", instr_count2, (t / 3 > 3) ? 3 : t / 3);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
